// File: rtl/zap_memory_main.sv
// Memory stage pipeline register: captures the ALU/memory instruction bundle
// and aligns the raw data-cache read word for loads.
module zap_memory_main #(
  parameter  int PHY_REGS = 46,
  parameter  int FLAG_WDT = 32,
  localparam int IW       = $clog2(PHY_REGS)
) (
  input  logic                i_clk,
  input  logic                i_reset,

  input  logic                i_clear_from_writeback,
  input  logic                i_data_stall,

  input  logic                i_alu_valid_ff,
  input  logic [31:0]         i_alu_result_ff,
  input  logic [FLAG_WDT-1:0] i_alu_flags_ff,
  input  logic [IW-1:0]       i_alu_destination_index_ff,

  input  logic                i_mem_load_ff,
  input  logic [IW-1:0]       i_mem_srcdest_index_ff,
  input  logic                i_mem_sbyte_ff,
  input  logic                i_mem_ubyte_ff,
  input  logic                i_mem_shalf_ff,
  input  logic                i_mem_uhalf_ff,
  input  logic [31:0]         i_mem_data,
  input  logic                i_data_abort,

  input  logic [31:0]         i_pc_plus_8_ff,
  input  logic                i_irq_ff,
  input  logic                i_fiq_ff,
  input  logic                i_instr_abt_ff,
  input  logic                i_swi_ff,
  input  logic                i_und_ff,

  output logic                o_valid,
  output logic [31:0]         o_alu_result_ff,
  output logic [FLAG_WDT-1:0] o_flags_ff,
  output logic [IW-1:0]       o_destination_index_ff,
  output logic                o_mem_load_ff,
  output logic [IW-1:0]       o_mem_srcdest_index_ff,
  output logic [31:0]         o_mem_rd_data,
  output logic [31:0]         o_pc_plus_8_ff,
  output logic                o_irq_ff,
  output logic                o_fiq_ff,
  output logic                o_instr_abt_ff,
  output logic                o_swi_ff,
  output logic                o_und_ff,
  output logic                o_data_abt_ff
);

  // Rotate right by whole bytes; a word load from an unaligned address.
  function automatic logic [31:0] rotate_bytes(input logic [31:0] d, input logic [1:0] a);
    logic [31:0] r;
    case (a)
      2'd0:    r = d;
      2'd1:    r = {d[7:0],  d[31:8]};
      2'd2:    r = {d[15:0], d[31:16]};
      default: r = {d[23:0], d[31:24]};
    endcase
    return r;
  endfunction

  // Size/sign selection; when several enables are set sbyte wins, then
  // ubyte, shalf, uhalf.
  function automatic logic [31:0] align_load(
    input logic [31:0] d,
    input logic [1:0]  a,
    input logic        sb,
    input logic        ub,
    input logic        sh,
    input logic        uh
  );
    logic [31:0]        rot;
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic [31:0]        r;
    rot = rotate_bytes(d, a);
    b   = rot[7:0];
    h   = a[1] ? d[31:16] : d[15:0];
    if (sb)      r = 32'(b);
    else if (ub) r = {24'd0, b};
    else if (sh) r = 32'(h);
    else if (uh) r = {16'd0, h};
    else         r = rot;
    return r;
  endfunction

  logic                valid_q,     valid_d;
  logic [31:0]         alu_res_q,   alu_res_d;
  logic [FLAG_WDT-1:0] flags_q,     flags_d;
  logic [IW-1:0]       dst_idx_q,   dst_idx_d;
  logic                mem_load_q,  mem_load_d;
  logic [IW-1:0]       sd_idx_q,    sd_idx_d;
  logic [31:0]         pc8_q,       pc8_d;
  logic                irq_q,       irq_d;
  logic                fiq_q,       fiq_d;
  logic                iabt_q,      iabt_d;
  logic                swi_q,       swi_d;
  logic                und_q,       und_d;
  logic                dabt_q,      dabt_d;
  logic [31:0]         rd_word_q,   rd_word_d;
  logic [1:0]          addr_lo_q,   addr_lo_d;
  logic                sbyte_q,     sbyte_d;
  logic                ubyte_q,     ubyte_d;
  logic                shalf_q,     shalf_d;
  logic                uhalf_q,     uhalf_d;

  always_comb begin
    valid_d    = valid_q;
    alu_res_d  = alu_res_q;
    flags_d    = flags_q;
    dst_idx_d  = dst_idx_q;
    mem_load_d = mem_load_q;
    sd_idx_d   = sd_idx_q;
    pc8_d      = pc8_q;
    irq_d      = irq_q;
    fiq_d      = fiq_q;
    iabt_d     = iabt_q;
    swi_d      = swi_q;
    und_d      = und_q;
    dabt_d     = dabt_q;
    rd_word_d  = rd_word_q;
    addr_lo_d  = addr_lo_q;
    sbyte_d    = sbyte_q;
    ubyte_d    = ubyte_q;
    shalf_d    = shalf_q;
    uhalf_d    = uhalf_q;

    // Flush dominates a stall: only the control bits need killing.
    if (i_clear_from_writeback) begin
      valid_d    = 1'b0;
      mem_load_d = 1'b0;
      irq_d      = 1'b0;
      fiq_d      = 1'b0;
      iabt_d     = 1'b0;
      swi_d      = 1'b0;
      und_d      = 1'b0;
      dabt_d     = 1'b0;
    end else if (!i_data_stall) begin
      valid_d    = i_alu_valid_ff;
      alu_res_d  = i_alu_result_ff;
      flags_d    = i_alu_flags_ff;
      dst_idx_d  = i_alu_destination_index_ff;
      mem_load_d = i_mem_load_ff & i_alu_valid_ff;
      sd_idx_d   = i_mem_srcdest_index_ff;
      pc8_d      = i_pc_plus_8_ff;
      irq_d      = i_irq_ff       & i_alu_valid_ff;
      fiq_d      = i_fiq_ff       & i_alu_valid_ff;
      iabt_d     = i_instr_abt_ff & i_alu_valid_ff;
      swi_d      = i_swi_ff       & i_alu_valid_ff;
      und_d      = i_und_ff       & i_alu_valid_ff;
      dabt_d     = i_data_abort   & i_alu_valid_ff & i_mem_load_ff;
      rd_word_d  = i_mem_data;
      addr_lo_d  = i_alu_result_ff[1:0];
      sbyte_d    = i_mem_sbyte_ff;
      ubyte_d    = i_mem_ubyte_ff;
      shalf_d    = i_mem_shalf_ff;
      uhalf_d    = i_mem_uhalf_ff;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      valid_q    <= 1'b0;
      alu_res_q  <= '0;
      flags_q    <= '0;
      dst_idx_q  <= '0;
      mem_load_q <= 1'b0;
      sd_idx_q   <= '0;
      pc8_q      <= '0;
      irq_q      <= 1'b0;
      fiq_q      <= 1'b0;
      iabt_q     <= 1'b0;
      swi_q      <= 1'b0;
      und_q      <= 1'b0;
      dabt_q     <= 1'b0;
      rd_word_q  <= '0;
      addr_lo_q  <= '0;
      sbyte_q    <= 1'b0;
      ubyte_q    <= 1'b0;
      shalf_q    <= 1'b0;
      uhalf_q    <= 1'b0;
    end else begin
      valid_q    <= valid_d;
      alu_res_q  <= alu_res_d;
      flags_q    <= flags_d;
      dst_idx_q  <= dst_idx_d;
      mem_load_q <= mem_load_d;
      sd_idx_q   <= sd_idx_d;
      pc8_q      <= pc8_d;
      irq_q      <= irq_d;
      fiq_q      <= fiq_d;
      iabt_q     <= iabt_d;
      swi_q      <= swi_d;
      und_q      <= und_d;
      dabt_q     <= dabt_d;
      rd_word_q  <= rd_word_d;
      addr_lo_q  <= addr_lo_d;
      sbyte_q    <= sbyte_d;
      ubyte_q    <= ubyte_d;
      shalf_q    <= shalf_d;
      uhalf_q    <= uhalf_d;
    end
  end

  // Aligned data comes only from latched state so it stays put across stalls.
  assign o_mem_rd_data = align_load(rd_word_q, addr_lo_q, sbyte_q, ubyte_q, shalf_q, uhalf_q);

  assign o_valid                = valid_q;
  assign o_alu_result_ff        = alu_res_q;
  assign o_flags_ff             = flags_q;
  assign o_destination_index_ff = dst_idx_q;
  assign o_mem_load_ff          = mem_load_q;
  assign o_mem_srcdest_index_ff = sd_idx_q;
  assign o_pc_plus_8_ff         = pc8_q;
  assign o_irq_ff               = irq_q;
  assign o_fiq_ff               = fiq_q;
  assign o_instr_abt_ff         = iabt_q;
  assign o_swi_ff               = swi_q;
  assign o_und_ff               = und_q;
  assign o_data_abt_ff          = dabt_q;

endmodule

// File: tb/tb_zap_memory_main.sv
// Directed bench for zap_memory_main: reset, load alignment, stall/flush
// priority and exception gating, against hand-computed values.
module tb_zap_memory_main;
  localparam int PHY_REGS = 46;
  localparam int FLAG_WDT = 32;
  localparam int IW       = $clog2(PHY_REGS);

  logic                i_clk = 1'b0;
  logic                i_reset;
  logic                i_clear_from_writeback;
  logic                i_data_stall;
  logic                i_alu_valid_ff;
  logic [31:0]         i_alu_result_ff;
  logic [FLAG_WDT-1:0] i_alu_flags_ff;
  logic [IW-1:0]       i_alu_destination_index_ff;
  logic                i_mem_load_ff;
  logic [IW-1:0]       i_mem_srcdest_index_ff;
  logic                i_mem_sbyte_ff, i_mem_ubyte_ff, i_mem_shalf_ff, i_mem_uhalf_ff;
  logic [31:0]         i_mem_data;
  logic                i_data_abort;
  logic [31:0]         i_pc_plus_8_ff;
  logic                i_irq_ff, i_fiq_ff, i_instr_abt_ff, i_swi_ff, i_und_ff;

  logic                o_valid;
  logic [31:0]         o_alu_result_ff;
  logic [FLAG_WDT-1:0] o_flags_ff;
  logic [IW-1:0]       o_destination_index_ff;
  logic                o_mem_load_ff;
  logic [IW-1:0]       o_mem_srcdest_index_ff;
  logic [31:0]         o_mem_rd_data;
  logic [31:0]         o_pc_plus_8_ff;
  logic                o_irq_ff, o_fiq_ff, o_instr_abt_ff, o_swi_ff, o_und_ff, o_data_abt_ff;

  int n_checks = 0;
  int n_errors = 0;

  always #5 i_clk = ~i_clk;

  zap_memory_main #(.PHY_REGS(PHY_REGS), .FLAG_WDT(FLAG_WDT)) dut (
    .i_clk                      (i_clk),
    .i_reset                    (i_reset),
    .i_clear_from_writeback     (i_clear_from_writeback),
    .i_data_stall               (i_data_stall),
    .i_alu_valid_ff             (i_alu_valid_ff),
    .i_alu_result_ff            (i_alu_result_ff),
    .i_alu_flags_ff             (i_alu_flags_ff),
    .i_alu_destination_index_ff (i_alu_destination_index_ff),
    .i_mem_load_ff              (i_mem_load_ff),
    .i_mem_srcdest_index_ff     (i_mem_srcdest_index_ff),
    .i_mem_sbyte_ff             (i_mem_sbyte_ff),
    .i_mem_ubyte_ff             (i_mem_ubyte_ff),
    .i_mem_shalf_ff             (i_mem_shalf_ff),
    .i_mem_uhalf_ff             (i_mem_uhalf_ff),
    .i_mem_data                 (i_mem_data),
    .i_data_abort               (i_data_abort),
    .i_pc_plus_8_ff             (i_pc_plus_8_ff),
    .i_irq_ff                   (i_irq_ff),
    .i_fiq_ff                   (i_fiq_ff),
    .i_instr_abt_ff             (i_instr_abt_ff),
    .i_swi_ff                   (i_swi_ff),
    .i_und_ff                   (i_und_ff),
    .o_valid                    (o_valid),
    .o_alu_result_ff            (o_alu_result_ff),
    .o_flags_ff                 (o_flags_ff),
    .o_destination_index_ff     (o_destination_index_ff),
    .o_mem_load_ff              (o_mem_load_ff),
    .o_mem_srcdest_index_ff     (o_mem_srcdest_index_ff),
    .o_mem_rd_data              (o_mem_rd_data),
    .o_pc_plus_8_ff             (o_pc_plus_8_ff),
    .o_irq_ff                   (o_irq_ff),
    .o_fiq_ff                   (o_fiq_ff),
    .o_instr_abt_ff             (o_instr_abt_ff),
    .o_swi_ff                   (o_swi_ff),
    .o_und_ff                   (o_und_ff),
    .o_data_abt_ff              (o_data_abt_ff)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle_inputs();
    i_reset = 1'b0;
    i_clear_from_writeback = 1'b0;
    i_data_stall = 1'b0;
    i_alu_valid_ff = 1'b0;
    i_alu_result_ff = '0;
    i_alu_flags_ff = '0;
    i_alu_destination_index_ff = '0;
    i_mem_load_ff = 1'b0;
    i_mem_srcdest_index_ff = '0;
    {i_mem_sbyte_ff, i_mem_ubyte_ff, i_mem_shalf_ff, i_mem_uhalf_ff} = 4'b0000;
    i_mem_data = '0;
    i_data_abort = 1'b0;
    i_pc_plus_8_ff = '0;
    {i_irq_ff, i_fiq_ff, i_instr_abt_ff, i_swi_ff, i_und_ff} = 5'b00000;
  endtask

  // size = {sbyte, ubyte, shalf, uhalf}
  task automatic set_load(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] size);
    i_alu_valid_ff  = 1'b1;
    i_mem_load_ff   = 1'b1;
    i_alu_result_ff = addr;
    i_mem_data      = data;
    {i_mem_sbyte_ff, i_mem_ubyte_ff, i_mem_shalf_ff, i_mem_uhalf_ff} = size;
  endtask

  typedef struct {
    string       tag;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  size;
    logic [31:0] exp;
  } load_vec_t;

  load_vec_t vecs[10];

  initial begin
    vecs[0] = '{"word_a2",       32'h0000_1002, 32'hAABB_CCDD, 4'b0000, 32'hCCDD_AABB};
    vecs[1] = '{"word_a0",       32'h0000_2000, 32'hAABB_CCDD, 4'b0000, 32'hAABB_CCDD};
    vecs[2] = '{"word_a1",       32'h0000_2001, 32'hAABB_CCDD, 4'b0000, 32'hDDAA_BBCC};
    vecs[3] = '{"sbyte_a3",      32'h0000_0003, 32'h8011_2233, 4'b1000, 32'hFFFF_FF80};
    vecs[4] = '{"ubyte_a3",      32'h0000_0003, 32'h8011_2233, 4'b0100, 32'h0000_0080};
    vecs[5] = '{"sbyte_a1",      32'h0000_0001, 32'h8011_2233, 4'b1000, 32'h0000_0022};
    vecs[6] = '{"shalf_a2",      32'h0000_0002, 32'h8001_1234, 4'b0010, 32'hFFFF_8001};
    vecs[7] = '{"shalf_a1",      32'h0000_0001, 32'h8001_1234, 4'b0010, 32'h0000_1234};
    vecs[8] = '{"uhalf_a2",      32'h0000_0002, 32'h8001_1234, 4'b0001, 32'h0000_8001};
    vecs[9] = '{"prio_sb_uh_a3", 32'h0000_0003, 32'h8011_2233, 4'b1001, 32'hFFFF_FF80};

    idle_inputs();
    i_reset = 1'b1;
    i_alu_valid_ff = 1'b1;
    i_irq_ff = 1'b1;
    i_alu_result_ff = 32'hDEAD_BEEF;
    tick();
    tick();
    chk("rst_valid",    o_valid, 0);
    chk("rst_load",     o_mem_load_ff, 0);
    chk("rst_irq",      o_irq_ff, 0);
    chk("rst_result",   o_alu_result_ff, 0);
    chk("rst_flags",    o_flags_ff, 0);
    chk("rst_pc",       o_pc_plus_8_ff, 0);
    chk("rst_dst",      o_destination_index_ff, 0);
    chk("rst_sd",       o_mem_srcdest_index_ff, 0);
    chk("rst_rd_data",  o_mem_rd_data, 0);

    // Full-bundle word load.
    idle_inputs();
    set_load(32'h0000_1002, 32'hAABB_CCDD, 4'b0000);
    i_alu_flags_ff = 32'hF000_0010;
    i_alu_destination_index_ff = 6'd5;
    i_mem_srcdest_index_ff = 6'd41;
    i_pc_plus_8_ff = 32'h0000_0108;
    tick();
    chk("word_valid",  o_valid, 1);
    chk("word_load",   o_mem_load_ff, 1);
    chk("word_rd",     o_mem_rd_data, 32'hCCDD_AABB);
    chk("word_result", o_alu_result_ff, 32'h0000_1002);
    chk("word_flags",  o_flags_ff, 32'hF000_0010);
    chk("word_dst",    o_destination_index_ff, 5);
    chk("word_sd",     o_mem_srcdest_index_ff, 41);
    chk("word_pc",     o_pc_plus_8_ff, 32'h0000_0108);
    chk("word_dabt",   o_data_abt_ff, 0);

    foreach (vecs[i]) begin
      idle_inputs();
      set_load(vecs[i].addr, vecs[i].data, vecs[i].size);
      tick();
      chk(vecs[i].tag, o_mem_rd_data, vecs[i].exp);
    end

    // Capture A, then stall three cycles while inputs change.
    idle_inputs();
    set_load(32'h0000_1002, 32'hAABB_CCDD, 4'b0000);
    i_alu_destination_index_ff = 6'd7;
    i_pc_plus_8_ff = 32'h0000_0200;
    tick();
    for (int c = 0; c < 3; c++) begin
      i_data_stall = 1'b1;
      set_load(32'h0000_3000 + c + 1, 32'h1111_1111 * (c + 3), 4'b1000);
      i_alu_destination_index_ff = 6'(c + 20);
      i_pc_plus_8_ff = 32'h0000_0900;
      i_irq_ff = 1'b1;
      tick();
      chk("stall_rd",     o_mem_rd_data, 32'hCCDD_AABB);
      chk("stall_result", o_alu_result_ff, 32'h0000_1002);
      chk("stall_dst",    o_destination_index_ff, 7);
      chk("stall_pc",     o_pc_plus_8_ff, 32'h0000_0200);
      chk("stall_valid",  o_valid, 1);
      chk("stall_irq",    o_irq_ff, 0);
    end

    // Reset while stalled overrides the stall; next edge captures normally.
    i_reset = 1'b1;
    tick();
    chk("rst_stall_valid",  o_valid, 0);
    chk("rst_stall_rd",     o_mem_rd_data, 0);
    chk("rst_stall_result", o_alu_result_ff, 0);
    idle_inputs();
    set_load(32'h0000_0003, 32'h8011_2233, 4'b0100);
    tick();
    chk("post_rst_valid", o_valid, 1);
    chk("post_rst_rd",    o_mem_rd_data, 32'h0000_0080);

    // Exception pass-through gated by valid.
    idle_inputs();
    i_alu_valid_ff = 1'b1;
    {i_irq_ff, i_fiq_ff, i_instr_abt_ff, i_swi_ff, i_und_ff} = 5'b11111;
    tick();
    chk("exc_valid_flags", {o_irq_ff, o_fiq_ff, o_instr_abt_ff, o_swi_ff, o_und_ff}, 5'b11111);
    chk("exc_valid_load",  o_mem_load_ff, 0);
    i_alu_valid_ff = 1'b0;
    tick();
    chk("exc_invalid_flags", {o_irq_ff, o_fiq_ff, o_instr_abt_ff, o_swi_ff, o_und_ff}, 5'b00000);

    // Stall and clear together: clear wins.
    idle_inputs();
    set_load(32'h0000_1000, 32'h1234_5678, 4'b0000);
    i_irq_ff = 1'b1;
    tick();
    chk("pre_clr_irq", o_irq_ff, 1);
    i_data_stall = 1'b1;
    i_clear_from_writeback = 1'b1;
    tick();
    chk("clr_valid", o_valid, 0);
    chk("clr_irq",   o_irq_ff, 0);
    chk("clr_load",  o_mem_load_ff, 0);

    // Data abort gating.
    idle_inputs();
    set_load(32'h0000_4000, 32'h0, 4'b0000);
    i_data_abort = 1'b1;
    tick();
    chk("dabt_on", o_data_abt_ff, 1);
    i_alu_valid_ff = 1'b0;
    tick();
    chk("dabt_invalid",       o_data_abt_ff, 0);
    chk("dabt_invalid_valid", o_valid, 0);
    i_alu_valid_ff = 1'b1;
    i_mem_load_ff = 1'b0;
    tick();
    chk("dabt_not_load", o_data_abt_ff, 0);
    chk("dabt_not_load_valid", o_valid, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
